// File: rtl/frame_composer.sv
// Per-frame compositor: scans the framebuffer once per vsync and writes map, map+sprite or faded pixels.
// The pipeline is address issue -> memory read -> write; fb_wr_ready low freezes all stages.
module frame_composer #(
  parameter int          FB_W      = 240,
  parameter int          FB_H      = 160,
  parameter int          MAP_W     = 464,
  parameter int          MAP_H     = 388,
  parameter int          SPR_W     = 16,
  parameter int          SPR_H     = 21,
  parameter int          SHEET_W   = 271,
  parameter int          ADDR_W    = 19,
  parameter logic [23:0] KEY_COLOR = 24'hFF00FF,
  parameter int          FADE_STEP = 1
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              VGA_VS,
  input  logic [1:0]        mode,
  input  logic [10:0]       cam_x,
  input  logic [10:0]       cam_y,
  input  logic [9:0]        spr_x,
  input  logic [9:0]        spr_y,
  input  logic [ADDR_W-1:0] spr_base,
  input  logic              spr_en,
  input  logic              spr_mirror,
  output logic [ADDR_W-1:0] map_addr,
  input  logic [23:0]       map_data,
  output logic [ADDR_W-1:0] spr_addr,
  input  logic [23:0]       spr_data,
  output logic [ADDR_W-1:0] fb_rd_addr,
  input  logic [23:0]       fb_rd_data,
  output logic [ADDR_W-1:0] fb_wr_addr,
  output logic [23:0]       fb_wr_data,
  output logic              fb_we,
  input  logic              fb_wr_ready,
  output logic              busy,
  output logic              frame_done,
  output logic [7:0]        frame_count,
  output logic              overrun
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t state;

  logic              vs_meta, vs_sync, vs_prev;
  logic              frame_start, stall, held;
  logic [9:0]        x, y;
  logic [1:0]        l_mode;
  logic [10:0]       l_cam_x, l_cam_y;
  logic [9:0]        l_spr_x, l_spr_y;
  logic [ADDR_W-1:0] l_spr_base;
  logic              l_spr_en, l_spr_mirror;
  logic              a_vld, a_in_map, a_spr_hit;
  logic [ADDR_W-1:0] a_wr_addr;
  logic              b_vld, b_in_map, b_spr_hit;
  logic [ADDR_W-1:0] b_wr_addr;
  logic [23:0]       map_hold, spr_hold, fbr_hold;

  logic [11:0]       mx, my;
  logic [9:0]        col, row, spr_col;
  logic              in_map, spr_hit, last_px;
  logic [ADDR_W-1:0] pix_idx, map_idx, spr_idx;
  logic [23:0]       map_q, spr_q, fbr_q, map_px, faded, pixel;

  assign frame_start = vs_prev & ~vs_sync;
  assign stall       = fb_we & ~fb_wr_ready;

  always_comb begin
    mx      = {l_cam_x[10], l_cam_x} + {2'b00, x};
    my      = {l_cam_y[10], l_cam_y} + {2'b00, y};
    in_map  = !mx[11] && (mx < 12'(MAP_W)) && !my[11] && (my < 12'(MAP_H));
    pix_idx = ADDR_W'(y) * ADDR_W'(FB_W) + ADDR_W'(x);
    map_idx = ADDR_W'(my) * ADDR_W'(MAP_W) + ADDR_W'(mx);
    col     = x - l_spr_x;
    row     = y - l_spr_y;
    spr_col = l_spr_mirror ? 10'(SPR_W - 1) - col : col;
    spr_idx = l_spr_base + ADDR_W'(row) * ADDR_W'(SHEET_W) + ADDR_W'(spr_col);
    spr_hit = (l_mode == 2'd2) && l_spr_en
           && ({1'b0, x} >= {1'b0, l_spr_x}) && ({1'b0, x} < {1'b0, l_spr_x} + 11'(SPR_W))
           && ({1'b0, y} >= {1'b0, l_spr_y}) && ({1'b0, y} < {1'b0, l_spr_y} + 11'(SPR_H));
    last_px = (x == 10'(FB_W - 1)) && (y == 10'(FB_H - 1));
  end

  // During a stall the memories already return data for the next address, so
  // the data belonging to the waiting pixel is captured on the first stall cycle.
  always_comb begin
    map_q  = held ? map_hold : map_data;
    spr_q  = held ? spr_hold : spr_data;
    fbr_q  = held ? fbr_hold : fb_rd_data;
    map_px = b_in_map ? map_q : '0;
    faded  = '0;
    for (int unsigned i = 0; i < 3; i++)
      faded[8*i +: 8] = (fbr_q[8*i +: 8] >= 8'(FADE_STEP)) ? fbr_q[8*i +: 8] - 8'(FADE_STEP) : 8'h00;
    case (l_mode)
      2'd2:    pixel = (b_spr_hit && spr_q != KEY_COLOR) ? spr_q : map_px;
      2'd3:    pixel = faded;
      default: pixel = map_px;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state        <= IDLE;
      vs_meta      <= 1'b1;
      vs_sync      <= 1'b1;
      vs_prev      <= 1'b1;
      x            <= '0;
      y            <= '0;
      l_mode       <= '0;
      l_cam_x      <= '0;
      l_cam_y      <= '0;
      l_spr_x      <= '0;
      l_spr_y      <= '0;
      l_spr_base   <= '0;
      l_spr_en     <= 1'b0;
      l_spr_mirror <= 1'b0;
      a_vld        <= 1'b0;
      a_in_map     <= 1'b0;
      a_spr_hit    <= 1'b0;
      a_wr_addr    <= '0;
      b_vld        <= 1'b0;
      b_in_map     <= 1'b0;
      b_spr_hit    <= 1'b0;
      b_wr_addr    <= '0;
      held         <= 1'b0;
      map_hold     <= '0;
      spr_hold     <= '0;
      fbr_hold     <= '0;
      map_addr     <= '0;
      spr_addr     <= '0;
      fb_rd_addr   <= '0;
      fb_wr_addr   <= '0;
      fb_wr_data   <= '0;
      fb_we        <= 1'b0;
      busy         <= 1'b0;
      frame_done   <= 1'b0;
      frame_count  <= '0;
      overrun      <= 1'b0;
    end else begin
      vs_meta    <= VGA_VS;
      vs_sync    <= vs_meta;
      vs_prev    <= vs_sync;
      frame_done <= 1'b0;
      held       <= stall;
      if (frame_start && state != IDLE) overrun <= 1'b1;
      if (stall && !held) begin
        map_hold <= map_data;
        spr_hold <= spr_data;
        fbr_hold <= fb_rd_data;
      end
      if (!stall) begin
        b_vld      <= a_vld;
        b_in_map   <= a_in_map;
        b_spr_hit  <= a_spr_hit;
        b_wr_addr  <= a_wr_addr;
        fb_we      <= b_vld;
        if (b_vld) begin
          fb_wr_addr <= b_wr_addr;
          fb_wr_data <= pixel;
        end
        a_vld      <= 1'b0;
        map_addr   <= '0;
        spr_addr   <= '0;
        fb_rd_addr <= '0;
      end
      case (state)
        IDLE: if (frame_start) begin
          l_mode       <= mode;
          l_cam_x      <= cam_x;
          l_cam_y      <= cam_y;
          l_spr_x      <= spr_x;
          l_spr_y      <= spr_y;
          l_spr_base   <= spr_base;
          l_spr_en     <= spr_en;
          l_spr_mirror <= spr_mirror;
          x            <= '0;
          y            <= '0;
          if (mode != 2'd0) begin
            state <= RUN;
            busy  <= 1'b1;
          end
        end
        RUN: if (!stall) begin
          a_vld      <= 1'b1;
          a_in_map   <= in_map && (l_mode != 2'd3);
          a_spr_hit  <= spr_hit;
          a_wr_addr  <= pix_idx;
          map_addr   <= (l_mode != 2'd3 && in_map) ? map_idx : '0;
          spr_addr   <= spr_hit ? spr_idx : '0;
          fb_rd_addr <= (l_mode == 2'd3) ? pix_idx : '0;
          if (x == 10'(FB_W - 1)) begin
            x <= '0;
            y <= y + 10'd1;
          end else begin
            x <= x + 10'd1;
          end
          if (last_px) state <= DRAIN;
        end
        DRAIN: if (!a_vld && !b_vld && !stall) begin
          state       <= DONE;
          frame_done  <= 1'b1;
          frame_count <= frame_count + 8'd1;
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_frame_composer.sv
// Directed bench for frame_composer on an 8x4 framebuffer with FADE_STEP=4.
module tb_frame_composer;
  localparam int          FB_W    = 8;
  localparam int          FB_H    = 4;
  localparam int          MAP_W   = 464;
  localparam int          SHEET_W = 271;
  localparam logic [23:0] KEY     = 24'hFF00FF;

  logic        Clk, Reset, VGA_VS;
  logic [1:0]  mode;
  logic [10:0] cam_x, cam_y;
  logic [9:0]  spr_x, spr_y;
  logic [18:0] spr_base;
  logic        spr_en, spr_mirror;
  logic [18:0] map_addr, spr_addr, fb_rd_addr, fb_wr_addr;
  logic [23:0] map_data, spr_data, fb_rd_data, fb_wr_data;
  logic        fb_we, fb_wr_ready, busy, frame_done, overrun;
  logic [7:0]  frame_count;

  frame_composer #(.FB_W(FB_W), .FB_H(FB_H), .FADE_STEP(4)) dut (
    .Clk(Clk), .Reset(Reset), .VGA_VS(VGA_VS), .mode(mode),
    .cam_x(cam_x), .cam_y(cam_y), .spr_x(spr_x), .spr_y(spr_y),
    .spr_base(spr_base), .spr_en(spr_en), .spr_mirror(spr_mirror),
    .map_addr(map_addr), .map_data(map_data), .spr_addr(spr_addr), .spr_data(spr_data),
    .fb_rd_addr(fb_rd_addr), .fb_rd_data(fb_rd_data),
    .fb_wr_addr(fb_wr_addr), .fb_wr_data(fb_wr_data), .fb_we(fb_we), .fb_wr_ready(fb_wr_ready),
    .busy(busy), .frame_done(frame_done), .frame_count(frame_count), .overrun(overrun)
  );

  int total = 0, bad = 0, exp_fc = 0;
  int cur_base = 1000, key_col = 0;
  bit fb_ramp = 0;
  int wr_cnt = 0, done_cnt = 0, spr_nz = 0;
  logic [18:0] wr_addr_log [1024];
  logic [23:0] wr_data_log [1024];

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic logic [23:0] map_fn(input logic [18:0] a);
    return 24'h400000 + {5'd0, a};
  endfunction

  function automatic logic [23:0] spr_fn(input logic [18:0] a);
    int off;
    if (int'(a) >= cur_base) begin
      off = int'(a) - cur_base;
      if (off % SHEET_W == key_col) return KEY;
    end
    return 24'h800000 + {5'd0, a};
  endfunction

  function automatic logic [23:0] fb_fn(input logic [18:0] a);
    return fb_ramp ? {a[7:0], 8'h02, 8'hFF} : 24'h030080;
  endfunction

  always @(posedge Clk) begin
    map_data   <= map_fn(map_addr);
    spr_data   <= spr_fn(spr_addr);
    fb_rd_data <= fb_fn(fb_rd_addr);
  end

  always @(negedge Clk) begin
    if (!Reset) begin
      if (fb_we && fb_wr_ready) begin
        if (wr_cnt < 1024) begin
          wr_addr_log[wr_cnt] = fb_wr_addr;
          wr_data_log[wr_cnt] = fb_wr_data;
        end
        wr_cnt++;
      end
      if (frame_done) done_cnt++;
      if (spr_addr != 19'd0) spr_nz++;
    end
  end

  task automatic step();
    @(posedge Clk);
    #2;
  endtask

  task automatic pulse_vs();
    VGA_VS = 1'b0;
    repeat (4) step();
    VGA_VS = 1'b1;
  endtask

  task automatic wait_done(input int d0, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400 && !ok; i++) begin
      step();
      if (done_cnt != d0) ok = 1'b1;
    end
    repeat (3) step();
  endtask

  task automatic test_reset();
    repeat (3) step();
    total++; if (fb_we !== 1'b0) begin bad++; $display("FAIL reset_we got=%b exp=0", fb_we); end
    total++; if (busy !== 1'b0 || frame_done !== 1'b0 || overrun !== 1'b0) begin
      bad++; $display("FAIL reset_flags got=%b%b%b exp=000", busy, frame_done, overrun); end
    total++; if (frame_count !== 8'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", frame_count); end
    total++; if (map_addr !== 19'd0 || spr_addr !== 19'd0 || fb_rd_addr !== 19'd0 || fb_wr_addr !== 19'd0) begin
      bad++; $display("FAIL reset_addr got=%h/%h/%h/%h exp=0", map_addr, spr_addr, fb_rd_addr, fb_wr_addr); end
    Reset = 1'b0;
    repeat (3) step();
  endtask

  task automatic test_basic();
    int b, d, s; bit ok;
    mode = 2'd1; cam_x = 11'd0; cam_y = 11'd0;
    b = wr_cnt; d = done_cnt; s = spr_nz;
    pulse_vs();
    mode = 2'd3; cam_x = 11'd5; spr_en = 1'b1;
    wait_done(d, ok);
    repeat (3) step();
    exp_fc++;
    total++; if (!ok) begin bad++; $display("FAIL basic_done got=timeout exp=frame_done"); end
    total++; if (wr_cnt - b != 32) begin bad++; $display("FAIL basic_count got=%0d exp=32", wr_cnt - b); end
    for (int i = 0; i < 32; i++) begin
      total++;
      if (wr_addr_log[b+i] !== 19'(i) || wr_data_log[b+i] !== map_fn(19'((i/8)*MAP_W + i%8))) begin
        bad++; $display("FAIL basic_px%0d got=%h/%h exp=%h/%h", i, wr_addr_log[b+i], wr_data_log[b+i],
                        19'(i), map_fn(19'((i/8)*MAP_W + i%8))); end
    end
    total++; if (done_cnt - d != 1) begin bad++; $display("FAIL basic_pulses got=%0d exp=1", done_cnt - d); end
    total++; if (frame_count !== 8'(exp_fc)) begin bad++; $display("FAIL basic_fc got=%0d exp=%0d", frame_count, exp_fc); end
    total++; if (spr_nz != s) begin bad++; $display("FAIL basic_spr_addr got=%0d exp=0", spr_nz - s); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL basic_busy got=%b exp=0", busy); end
    mode = 2'd1; cam_x = 11'd0; spr_en = 1'b0;
  endtask

  task automatic test_latency();
    int b, d, ac, wc;
    logic [18:0] a0;
    mode = 2'd1; cam_x = 11'd1; cam_y = 11'd0;
    b = wr_cnt; d = done_cnt; ac = -1; wc = -1; a0 = '0;
    VGA_VS = 1'b0;
    for (int i = 0; i < 80; i++) begin
      step();
      if (i == 3) VGA_VS = 1'b1;
      if (ac < 0 && map_addr != 19'd0) begin ac = i; a0 = map_addr; end
      if (wc < 0 && fb_we) wc = i;
    end
    exp_fc++;
    total++; if (ac < 0 || wc - ac != 2) begin bad++; $display("FAIL latency got=%0d exp=2", wc - ac); end
    total++; if (a0 !== 19'd1) begin bad++; $display("FAIL latency_addr got=%h exp=1", a0); end
    total++; if (wr_data_log[b] !== map_fn(19'd1)) begin bad++; $display("FAIL latency_data got=%h exp=%h", wr_data_log[b], map_fn(19'd1)); end
    total++; if (done_cnt - d != 1 || frame_count !== 8'(exp_fc)) begin
      bad++; $display("FAIL latency_done got=%0d/%0d exp=1/%0d", done_cnt - d, frame_count, exp_fc); end
    cam_x = 11'd0;
  endtask

  task automatic test_offsets(input logic [10:0] cx, input logic [10:0] cy, input int xin, input int yin);
    int b, d, x, y; bit ok;
    logic [23:0] e;
    mode = 2'd1; cam_x = cx; cam_y = cy;
    b = wr_cnt; d = done_cnt;
    pulse_vs();
    wait_done(d, ok);
    exp_fc++;
    total++; if (!ok || wr_cnt - b != 32) begin bad++; $display("FAIL offs_count got=%0d exp=32", wr_cnt - b); end
    for (int i = 0; i < 32; i++) begin
      x = i % 8; y = i / 8;
      if (xin < 0) e = (x < 3) ? 24'h0 : map_fn(19'(y*MAP_W + x - 3));
      else e = (x < xin && y < yin) ? map_fn(19'((386 + y)*MAP_W + 459 + x)) : 24'h0;
      total++;
      if (wr_data_log[b+i] !== e) begin bad++; $display("FAIL offs_px%0d got=%h exp=%h", i, wr_data_log[b+i], e); end
    end
    cam_x = 11'd0; cam_y = 11'd0;
  endtask

  task automatic test_sprite(input bit mir);
    int b, d; bit ok;
    int idx [7];
    logic [23:0] e [7];
    mode = 2'd2; spr_x = 10'd2; spr_y = 10'd1; spr_base = 19'd1000; spr_en = 1'b1; spr_mirror = mir;
    cur_base = 1000; key_col = mir ? 15 : 0;
    idx = '{10, 11, 8, 20, 2, 26, 31};
    e[0] = map_fn(19'd466);
    e[1] = mir ? 24'h800000 + 24'd1014 : 24'h800000 + 24'd1001;
    e[2] = map_fn(19'd464);
    e[3] = mir ? 24'h800000 + 24'd1284 : 24'h800000 + 24'd1273;
    e[4] = map_fn(19'd2);
    e[5] = map_fn(19'd1394);
    e[6] = mir ? 24'h800000 + 24'd1552 : 24'h800000 + 24'd1547;
    b = wr_cnt; d = done_cnt;
    pulse_vs();
    wait_done(d, ok);
    exp_fc++;
    total++; if (!ok || wr_cnt - b != 32) begin bad++; $display("FAIL spr_count got=%0d exp=32", wr_cnt - b); end
    for (int k = 0; k < 7; k++) begin
      total++;
      if (wr_data_log[b+idx[k]] !== e[k]) begin
        bad++; $display("FAIL spr_m%0d_px%0d got=%h exp=%h", mir, idx[k], wr_data_log[b+idx[k]], e[k]); end
    end
    mode = 2'd1; spr_en = 1'b0; spr_mirror = 1'b0;
  endtask

  task automatic test_fade();
    int b, d; bit ok;
    int idx [6];
    logic [7:0] r [6];
    mode = 2'd3; fb_ramp = 1'b0;
    b = wr_cnt; d = done_cnt;
    pulse_vs();
    wait_done(d, ok);
    exp_fc++;
    total++; if (!ok || wr_cnt - b != 32) begin bad++; $display("FAIL fade_count got=%0d exp=32", wr_cnt - b); end
    for (int i = 0; i < 32; i++) begin
      total++;
      if (wr_addr_log[b+i] !== 19'(i) || wr_data_log[b+i] !== 24'h00007C) begin
        bad++; $display("FAIL fade_px%0d got=%h/%h exp=%h/00007c", i, wr_addr_log[b+i], wr_data_log[b+i], 19'(i)); end
    end
    fb_ramp = 1'b1;
    idx = '{0, 3, 4, 5, 10, 31};
    r = '{8'h00, 8'h00, 8'h00, 8'h01, 8'h06, 8'h1B};
    b = wr_cnt; d = done_cnt;
    pulse_vs();
    wait_done(d, ok);
    exp_fc++;
    for (int k = 0; k < 6; k++) begin
      total++;
      if (wr_data_log[b+idx[k]] !== {r[k], 8'h00, 8'hFB}) begin
        bad++; $display("FAIL fade_ramp_px%0d got=%h exp=%h", idx[k], wr_data_log[b+idx[k]], {r[k], 8'h00, 8'hFB}); end
    end
    fb_ramp = 1'b0; mode = 2'd1;
  endtask

  task automatic test_stall();
    int b, d, n, p; bit ok;
    mode = 2'd1; cam_x = 11'd0; cam_y = 11'd0;
    b = wr_cnt; d = done_cnt;
    pulse_vs();
    for (int i = 0; i < 100 && wr_cnt - b < 5; i++) step();
    fb_wr_ready = 1'b0;
    n = wr_cnt - b; p = n + 2;
    for (int k = 0; k < 5; k++) begin
      step();
      total++;
      if (fb_we !== 1'b1 || fb_wr_addr !== 19'(n) || fb_wr_data !== map_fn(19'((n/8)*MAP_W + n%8))
          || map_addr !== 19'((p/8)*MAP_W + p%8) || wr_cnt - b != n) begin
        bad++; $display("FAIL stall_hold%0d got=%b/%h/%h/%h exp=1/%h/%h/%h", k, fb_we, fb_wr_addr, fb_wr_data,
                        map_addr, 19'(n), map_fn(19'((n/8)*MAP_W + n%8)), 19'((p/8)*MAP_W + p%8)); end
    end
    fb_wr_ready = 1'b1;
    wait_done(d, ok);
    exp_fc++;
    total++; if (!ok || wr_cnt - b != 32) begin bad++; $display("FAIL stall_count got=%0d exp=32", wr_cnt - b); end
    for (int i = 0; i < 32; i++) begin
      total++;
      if (wr_addr_log[b+i] !== 19'(i) || wr_data_log[b+i] !== map_fn(19'((i/8)*MAP_W + i%8))) begin
        bad++; $display("FAIL stall_px%0d got=%h/%h", i, wr_addr_log[b+i], wr_data_log[b+i]); end
    end
  endtask

  task automatic test_overrun();
    int b, d; bit ok;
    mode = 2'd1;
    b = wr_cnt; d = done_cnt;
    pulse_vs();
    for (int i = 0; i < 100 && wr_cnt - b < 3; i++) step();
    pulse_vs();
    total++; if (overrun !== 1'b1) begin bad++; $display("FAIL overrun_set got=%b exp=1", overrun); end
    wait_done(d, ok);
    repeat (10) step();
    exp_fc++;
    total++; if (!ok || wr_cnt - b != 32 || done_cnt - d != 1) begin
      bad++; $display("FAIL overrun_frame got=%0d/%0d exp=32/1", wr_cnt - b, done_cnt - d); end
    total++; if (overrun !== 1'b1 || frame_count !== 8'(exp_fc)) begin
      bad++; $display("FAIL overrun_sticky got=%b/%0d exp=1/%0d", overrun, frame_count, exp_fc); end
  endtask

  task automatic test_mode0();
    int b, d, bz;
    mode = 2'd0; b = wr_cnt; d = done_cnt; bz = 0;
    VGA_VS = 1'b0;
    for (int i = 0; i < 60; i++) begin
      step();
      if (i == 3) VGA_VS = 1'b1;
      if (busy) bz++;
    end
    total++; if (bz != 0 || wr_cnt != b || done_cnt != d) begin
      bad++; $display("FAIL mode0 got=%0d/%0d/%0d exp=0/0/0", bz, wr_cnt - b, done_cnt - d); end
    total++; if (frame_count !== 8'(exp_fc)) begin bad++; $display("FAIL mode0_fc got=%0d exp=%0d", frame_count, exp_fc); end
    mode = 2'd1;
  endtask

  task automatic test_reset_mid();
    int b, d, n; bit ok;
    mode = 2'd1;
    b = wr_cnt;
    pulse_vs();
    for (int i = 0; i < 100 && wr_cnt - b < 10; i++) step();
    Reset = 1'b1;
    #1;
    total++; if (fb_we !== 1'b0 || busy !== 1'b0 || overrun !== 1'b0 || frame_count !== 8'd0 || map_addr !== 19'd0) begin
      bad++; $display("FAIL rst_mid got=%b/%b/%b/%0d/%h exp=0/0/0/0/0", fb_we, busy, overrun, frame_count, map_addr); end
    repeat (3) step();
    Reset = 1'b0;
    n = wr_cnt;
    repeat (8) step();
    exp_fc = 0;
    total++; if (wr_cnt != n || busy !== 1'b0) begin bad++; $display("FAIL rst_quiet got=%0d/%b exp=0/0", wr_cnt - n, busy); end
    b = wr_cnt; d = done_cnt;
    pulse_vs();
    wait_done(d, ok);
    exp_fc++;
    total++; if (!ok || wr_cnt - b != 32) begin bad++; $display("FAIL rst_next_count got=%0d exp=32", wr_cnt - b); end
    total++; if (wr_addr_log[b] !== 19'd0 || wr_data_log[b] !== map_fn(19'd0)) begin
      bad++; $display("FAIL rst_next_first got=%h/%h exp=0/%h", wr_addr_log[b], wr_data_log[b], map_fn(19'd0)); end
    total++; if (frame_count !== 8'(exp_fc)) begin bad++; $display("FAIL rst_next_fc got=%0d exp=%0d", frame_count, exp_fc); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset = 1'b1; VGA_VS = 1'b1; mode = 2'd1; cam_x = '0; cam_y = '0;
    spr_x = '0; spr_y = '0; spr_base = '0; spr_en = 1'b0; spr_mirror = 1'b0;
    fb_wr_ready = 1'b1;
    test_reset();
    test_basic();
    test_latency();
    test_offsets(11'h7FD, 11'd0, -1, 0);
    test_offsets(11'd459, 11'd386, 5, 2);
    test_sprite(1'b1);
    test_sprite(1'b0);
    test_fade();
    test_stall();
    test_overrun();
    test_mode0();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
